// File: rtl/execute_md.sv
// execute_md: MIPS execute stage with operand forwarding, ALU, branch compare,
// destination select, EX/MEM pipeline register and an iterative multiply/divide
// unit holding HI/LO. Define EXECUTE_MD_DIV_EN to include the divider; without
// it DIV/DIVU are no-ops.
module execute_md #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_con_hold,
  input  logic              i_con_flush,
  input  logic [DATA_W-1:0] i_data_pc4,
  input  logic [DATA_W-1:0] i_data_rs,
  input  logic [DATA_W-1:0] i_data_rt,
  input  logic [DATA_W-1:0] i_data_immext,
  input  logic [4:0]        i_addr_rt,
  input  logic [4:0]        i_addr_rd,
  input  logic [DATA_W-1:0] i_data_FEalures,
  input  logic [DATA_W-1:0] i_data_FMalures,
  input  logic [DATA_W-1:0] i_data_FMmemout,
  input  logic [DATA_W-1:0] i_data_FWmemout,
  input  logic [2:0]        i_con_Efamux,
  input  logic [2:0]        i_con_Efbmux,
  input  logic [3:0]        i_con_Ealuctrl,
  input  logic              i_con_Ealusrc,
  input  logic              i_con_Eregdst,
  input  logic [2:0]        i_con_Emdop,
  input  logic [1:0]        i_con_Emfhl,
  input  logic [2:0]        i_con_bop,
  input  logic              i_con_Mmemread,
  input  logic              i_con_Mmemwrite,
  input  logic              i_con_Walupc8,
  input  logic              i_con_Wmemtoreg,
  input  logic              i_con_Wregwrite,
  output logic [DATA_W-1:0] o_data_pc4,
  output logic [DATA_W-1:0] o_data_alures,
  output logic [DATA_W-1:0] o_data_rt,
  output logic [4:0]        o_addr_regdst,
  output logic [4:0]        o_addr_Mrt,
  output logic              o_con_Mmemread,
  output logic              o_con_Mmemwrite,
  output logic              o_con_Walupc8,
  output logic              o_con_Wmemtoreg,
  output logic              o_con_Wregwrite,
  output logic [4:0]        o_addr_Erd,
  output logic              o_con_ifbranch,
  output logic              o_con_stall,
  output logic              o_con_mdbusy
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  logic [DATA_W-1:0] opa, fwd_b, opb, alu_res, ex_res;
  logic [SH_W-1:0]   shamt;
  logic [4:0]        dest;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*DATA_W-1:0] work_q, step_next, mul_next, start_work;
  logic [DATA_W-1:0] opm_q, start_opm, hi_q, lo_q, fin_hi, fin_lo;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum;
  logic              neg_prod_q, a_neg, b_neg, signed_op;
  logic              busy, needs_md, issue_ok, start_mul, start_div, start, finish;
  logic              wr_hi, wr_lo;

  logic [DATA_W-1:0] pc4_q, alures_q, rt_q;
  logic [4:0]        regdst_q, mrt_q;
  logic              memread_q, memwrite_q, alupc8_q, memtoreg_q, regwrite_q;

  assign shamt = i_data_immext[6+SH_W-1:6];

  // Forwarding select for the A operand.
  always_comb begin
    unique case (i_con_Efamux)
      3'd1:    opa = i_data_FEalures;
      3'd2:    opa = i_data_FMalures;
      3'd3:    opa = i_data_FMmemout;
      3'd4:    opa = i_data_FWmemout;
      default: opa = i_data_rs;
    endcase
  end

  // Forwarding select for the rt operand.
  always_comb begin
    unique case (i_con_Efbmux)
      3'd1:    fwd_b = i_data_FEalures;
      3'd2:    fwd_b = i_data_FMalures;
      3'd3:    fwd_b = i_data_FMmemout;
      3'd4:    fwd_b = i_data_FWmemout;
      default: fwd_b = i_data_rt;
    endcase
  end

  assign opb = i_con_Ealusrc ? i_data_immext : fwd_b;

  // ALU.
  always_comb begin
    unique case (i_con_Ealuctrl)
      4'd0:    alu_res = opa & opb;
      4'd1:    alu_res = opa | opb;
      4'd2:    alu_res = opa + opb;
      4'd3:    alu_res = opa - opb;
      4'd4:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      4'd5:    alu_res = {{(DATA_W-1){1'b0}}, (opa < opb)};
      4'd6:    alu_res = ~(opa | opb);
      4'd7:    alu_res = opa ^ opb;
      4'd8:    alu_res = opb << shamt;
      4'd9:    alu_res = opb >> shamt;
      4'd10:   alu_res = $signed(opb) >>> shamt;
      4'd11:   alu_res = opb << (DATA_W / 2);
      default: alu_res = '0;
    endcase
  end

  // Result select between ALU and HI/LO.
  always_comb begin
    unique case (i_con_Emfhl)
      2'd1:    ex_res = hi_q;
      2'd2:    ex_res = lo_q;
      default: ex_res = alu_res;
    endcase
  end

  // Branch compare; the zero compares look only at A.
  always_comb begin
    unique case (i_con_bop)
      3'd1:    o_con_ifbranch = (opa == fwd_b);
      3'd2:    o_con_ifbranch = (opa != fwd_b);
      3'd3:    o_con_ifbranch = opa[DATA_W-1] | (opa == '0);
      3'd4:    o_con_ifbranch = ~opa[DATA_W-1] & (opa != '0);
      3'd5:    o_con_ifbranch = opa[DATA_W-1];
      3'd6:    o_con_ifbranch = ~opa[DATA_W-1];
      default: o_con_ifbranch = 1'b0;
    endcase
  end

  assign dest       = i_con_Walupc8 ? 5'd31 : (i_con_Eregdst ? i_addr_rd : i_addr_rt);
  assign o_addr_Erd = dest;

  // MDU issue and hazard decode.
  assign busy        = (state_q == StBusy);
  assign needs_md    = ((i_con_Emdop != 3'd0) && (i_con_Emdop != 3'd7)) ||
                       (i_con_Emfhl == 2'd1) || (i_con_Emfhl == 2'd2);
  assign o_con_stall = busy & needs_md;
  assign issue_ok    = ~busy & ~i_con_hold & ~i_con_flush;
  assign start_mul   = issue_ok & ((i_con_Emdop == 3'd1) || (i_con_Emdop == 3'd2));
`ifdef EXECUTE_MD_DIV_EN
  assign start_div   = issue_ok & ((i_con_Emdop == 3'd3) || (i_con_Emdop == 3'd4));
  assign signed_op   = (i_con_Emdop == 3'd1) || (i_con_Emdop == 3'd3);
`else
  assign start_div   = 1'b0;
  assign signed_op   = (i_con_Emdop == 3'd1);
`endif
  assign start       = start_mul | start_div;
  assign wr_hi       = issue_ok & (i_con_Emdop == 3'd5);
  assign wr_lo       = issue_ok & (i_con_Emdop == 3'd6);
  assign o_con_mdbusy = busy;

  assign a_neg = signed_op & opa[DATA_W-1];
  assign b_neg = signed_op & fwd_b[DATA_W-1];
  assign a_mag = a_neg ? ('0 - opa) : opa;
  assign b_mag = b_neg ? ('0 - fwd_b) : fwd_b;

  // Multiply keeps {partial, multiplier} in work_q, multiplicand in opm_q.
  assign mul_sum  = {1'b0, work_q[2*DATA_W-1:DATA_W]} +
                    {1'b0, (work_q[0] ? opm_q : {DATA_W{1'b0}})};
  assign mul_next = {mul_sum, work_q[DATA_W-1:1]};

`ifdef EXECUTE_MD_DIV_EN
  // Divide keeps {remainder, dividend/quotient} in work_q, divisor in opm_q.
  logic              is_div_q, neg_rem_q, dz_q;
  logic [DATA_W:0]   div_shift, div_diff;
  logic [2*DATA_W-1:0] div_next, mul_fin;
  logic [DATA_W-1:0] quo, rem;

  assign div_shift = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opm_q};
  assign div_next  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};
  assign step_next = is_div_q ? div_next : mul_next;
  assign mul_fin   = neg_prod_q ? ('0 - step_next) : step_next;
  assign quo       = step_next[DATA_W-1:0];
  assign rem       = step_next[2*DATA_W-1:DATA_W];

  // Final sign correction; a zero divisor forces an all-ones quotient while the
  // remainder naturally carries the dividend through.
  always_comb begin
    fin_hi = mul_fin[2*DATA_W-1:DATA_W];
    fin_lo = mul_fin[DATA_W-1:0];
    if (is_div_q) begin
      fin_hi = neg_rem_q ? ('0 - rem) : rem;
      fin_lo = dz_q ? {DATA_W{1'b1}} : (neg_prod_q ? ('0 - quo) : quo);
    end
  end

  // Operand loading for either operation.
  always_comb begin
    start_work = {{DATA_W{1'b0}}, b_mag};
    start_opm  = a_mag;
    if (start_div) begin
      start_work = {{DATA_W{1'b0}}, a_mag};
      start_opm  = b_mag;
    end
  end

  // Divide-only operation flags latched at start.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (start) begin
      is_div_q  <= start_div;
      neg_rem_q <= a_neg;
      dz_q      <= (fwd_b == '0);
    end
  end
`else
  logic [2*DATA_W-1:0] mul_fin;

  assign step_next  = mul_next;
  assign mul_fin    = neg_prod_q ? ('0 - step_next) : step_next;
  assign fin_hi     = mul_fin[2*DATA_W-1:DATA_W];
  assign fin_lo     = mul_fin[DATA_W-1:0];
  assign start_work = {{DATA_W{1'b0}}, b_mag};
  assign start_opm  = a_mag;
`endif

  // MDU FSM next state and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          cnt_d   = CNT_W'(DATA_W);
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // MDU FSM state register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MDU datapath and HI/LO; MTHI/MTLO only happen while idle.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      work_q     <= '0;
      opm_q      <= '0;
      neg_prod_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (start) begin
        work_q     <= start_work;
        opm_q      <= start_opm;
        neg_prod_q <= a_neg ^ b_neg;
      end else if (busy) begin
        work_q <= step_next;
      end
      if (finish) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end else begin
        if (wr_hi) hi_q <= opa;
        if (wr_lo) lo_q <= opa;
      end
    end
  end

  // EX/MEM register: hold freezes; flush or stall inserts a control bubble.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pc4_q      <= '0;
      alures_q   <= '0;
      rt_q       <= '0;
      regdst_q   <= '0;
      mrt_q      <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alupc8_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!i_con_hold) begin
      pc4_q    <= i_data_pc4;
      alures_q <= ex_res;
      rt_q     <= fwd_b;
      regdst_q <= dest;
      mrt_q    <= i_addr_rt;
      if (i_con_flush || o_con_stall) begin
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        alupc8_q   <= 1'b0;
        memtoreg_q <= 1'b0;
        regwrite_q <= 1'b0;
      end else begin
        memread_q  <= i_con_Mmemread;
        memwrite_q <= i_con_Mmemwrite;
        alupc8_q   <= i_con_Walupc8;
        memtoreg_q <= i_con_Wmemtoreg;
        regwrite_q <= i_con_Wregwrite;
      end
    end
  end

  assign o_data_pc4      = pc4_q;
  assign o_data_alures   = alures_q;
  assign o_data_rt       = rt_q;
  assign o_addr_regdst   = regdst_q;
  assign o_addr_Mrt      = mrt_q;
  assign o_con_Mmemread  = memread_q;
  assign o_con_Mmemwrite = memwrite_q;
  assign o_con_Walupc8   = alupc8_q;
  assign o_con_Wmemtoreg = memtoreg_q;
  assign o_con_Wregwrite = regwrite_q;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md (DATA_W = 32).
module tb_execute_md;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_con_hold, i_con_flush;
  logic [31:0] i_data_pc4, i_data_rs, i_data_rt, i_data_immext;
  logic [4:0]  i_addr_rt, i_addr_rd;
  logic [31:0] i_data_FEalures, i_data_FMalures, i_data_FMmemout, i_data_FWmemout;
  logic [2:0]  i_con_Efamux, i_con_Efbmux;
  logic [3:0]  i_con_Ealuctrl;
  logic        i_con_Ealusrc, i_con_Eregdst;
  logic [2:0]  i_con_Emdop;
  logic [1:0]  i_con_Emfhl;
  logic [2:0]  i_con_bop;
  logic        i_con_Mmemread, i_con_Mmemwrite, i_con_Walupc8, i_con_Wmemtoreg;
  logic        i_con_Wregwrite;
  logic [31:0] o_data_pc4, o_data_alures, o_data_rt;
  logic [4:0]  o_addr_regdst, o_addr_Mrt, o_addr_Erd;
  logic        o_con_Mmemread, o_con_Mmemwrite, o_con_Walupc8, o_con_Wmemtoreg;
  logic        o_con_Wregwrite, o_con_ifbranch, o_con_stall, o_con_mdbusy;

  int n_cmp  = 0;
  int n_fail = 0;

  execute_md #(.DATA_W(32)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_con_hold(i_con_hold), .i_con_flush(i_con_flush),
    .i_data_pc4(i_data_pc4), .i_data_rs(i_data_rs), .i_data_rt(i_data_rt),
    .i_data_immext(i_data_immext), .i_addr_rt(i_addr_rt), .i_addr_rd(i_addr_rd),
    .i_data_FEalures(i_data_FEalures), .i_data_FMalures(i_data_FMalures),
    .i_data_FMmemout(i_data_FMmemout), .i_data_FWmemout(i_data_FWmemout),
    .i_con_Efamux(i_con_Efamux), .i_con_Efbmux(i_con_Efbmux),
    .i_con_Ealuctrl(i_con_Ealuctrl), .i_con_Ealusrc(i_con_Ealusrc),
    .i_con_Eregdst(i_con_Eregdst), .i_con_Emdop(i_con_Emdop), .i_con_Emfhl(i_con_Emfhl),
    .i_con_bop(i_con_bop), .i_con_Mmemread(i_con_Mmemread),
    .i_con_Mmemwrite(i_con_Mmemwrite), .i_con_Walupc8(i_con_Walupc8),
    .i_con_Wmemtoreg(i_con_Wmemtoreg), .i_con_Wregwrite(i_con_Wregwrite),
    .o_data_pc4(o_data_pc4), .o_data_alures(o_data_alures), .o_data_rt(o_data_rt),
    .o_addr_regdst(o_addr_regdst), .o_addr_Mrt(o_addr_Mrt),
    .o_con_Mmemread(o_con_Mmemread), .o_con_Mmemwrite(o_con_Mmemwrite),
    .o_con_Walupc8(o_con_Walupc8), .o_con_Wmemtoreg(o_con_Wmemtoreg),
    .o_con_Wregwrite(o_con_Wregwrite), .o_addr_Erd(o_addr_Erd),
    .o_con_ifbranch(o_con_ifbranch), .o_con_stall(o_con_stall), .o_con_mdbusy(o_con_mdbusy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_con_hold = 0; i_con_flush = 0;
    i_data_pc4 = 0; i_data_rs = 0; i_data_rt = 0; i_data_immext = 0;
    i_addr_rt = 0; i_addr_rd = 0;
    i_data_FEalures = 0; i_data_FMalures = 0; i_data_FMmemout = 0; i_data_FWmemout = 0;
    i_con_Efamux = 0; i_con_Efbmux = 0; i_con_Ealuctrl = 0; i_con_Ealusrc = 0;
    i_con_Eregdst = 0; i_con_Emdop = 0; i_con_Emfhl = 0; i_con_bop = 0;
    i_con_Mmemread = 0; i_con_Mmemwrite = 0; i_con_Walupc8 = 0; i_con_Wmemtoreg = 0;
    i_con_Wregwrite = 0;
  endtask

  // Read HI (sel=1) or LO (sel=2) through the EX/MEM register.
  task automatic read_hl(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    idle_inputs();
    i_con_Emfhl = sel;
    i_con_Wregwrite = 1;
    step();
    chk(tag, o_data_alures, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_con_mdbusy && n < 100) begin n++; step(); end
    chk("mdu_idle_bound", {31'd0, o_con_mdbusy}, 32'd0);
  endtask

  logic [3:0]  v_op  [12];
  logic [31:0] v_a   [12];
  logic [31:0] v_b   [12];
  logic [31:0] v_exp [12];

  initial begin
    int n;
    v_op[0]  = 4'd0;  v_a[0]  = 32'hF0F0F0F0; v_b[0]  = 32'hFF00FF00; v_exp[0]  = 32'hF000F000;
    v_op[1]  = 4'd1;  v_a[1]  = 32'hF0F0F0F0; v_b[1]  = 32'hFF00FF00; v_exp[1]  = 32'hFFF0FFF0;
    v_op[2]  = 4'd3;  v_a[2]  = 32'd5;        v_b[2]  = 32'd7;        v_exp[2]  = 32'hFFFFFFFE;
    v_op[3]  = 4'd4;  v_a[3]  = 32'hFFFFFFFF; v_b[3]  = 32'd1;        v_exp[3]  = 32'd1;
    v_op[4]  = 4'd5;  v_a[4]  = 32'hFFFFFFFF; v_b[4]  = 32'd1;        v_exp[4]  = 32'd0;
    v_op[5]  = 4'd6;  v_a[5]  = 32'hF0F0F0F0; v_b[5]  = 32'h0F0F0000; v_exp[5]  = 32'h00000F0F;
    v_op[6]  = 4'd7;  v_a[6]  = 32'hFF00FF00; v_b[6]  = 32'h0FF00FF0; v_exp[6]  = 32'hF0F0F0F0;
    v_op[7]  = 4'd8;  v_a[7]  = 32'd0;        v_b[7]  = 32'd1;        v_exp[7]  = 32'h00000010;
    v_op[8]  = 4'd9;  v_a[8]  = 32'd0;        v_b[8]  = 32'h80000000; v_exp[8]  = 32'h08000000;
    v_op[9]  = 4'd10; v_a[9]  = 32'd0;        v_b[9]  = 32'h80000000; v_exp[9]  = 32'hF8000000;
    v_op[10] = 4'd11; v_a[10] = 32'd0;        v_b[10] = 32'h00001234; v_exp[10] = 32'h12340000;
    v_op[11] = 4'd12; v_a[11] = 32'd9;        v_b[11] = 32'd9;        v_exp[11] = 32'd0;

    // Reset
    idle_inputs();
    i_nrst = 0;
    i_con_Emdop = 3'd1;
    i_con_Wregwrite = 1;
    step(); step();
    chk("rst_alures", o_data_alures, 32'd0);
    chk("rst_pc4", o_data_pc4, 32'd0);
    chk("rst_regwrite", {31'd0, o_con_Wregwrite}, 32'd0);
    chk("rst_busy", {31'd0, o_con_mdbusy}, 32'd0);
    chk("rst_stall", {31'd0, o_con_stall}, 32'd0);
    idle_inputs();
    i_nrst = 1;
    step();

    // Forwarding from FMmemout, ADD with immediate, rd destination
    i_con_Efamux = 3'd3; i_data_FMmemout = 32'h1234; i_data_rs = 32'h5555;
    i_con_Ealuctrl = 4'd2; i_con_Ealusrc = 1; i_data_immext = 32'd1;
    i_con_Eregdst = 1; i_addr_rd = 5'd9; i_addr_rt = 5'd4;
    i_con_Wregwrite = 1; i_data_pc4 = 32'h100;
    #1 chk("erd_rd", {27'd0, o_addr_Erd}, 32'd9);
    step();
    chk("fwd_add", o_data_alures, 32'h1235);
    chk("regdst_rd", {27'd0, o_addr_regdst}, 32'd9);
    chk("pc4", o_data_pc4, 32'h100);
    chk("regwrite", {31'd0, o_con_Wregwrite}, 32'd1);
    i_con_Walupc8 = 1;
    step();
    chk("regdst_31", {27'd0, o_addr_regdst}, 32'd31);

    // ALU table, B taken from rt, shamt field = 4
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      i_con_Ealuctrl = v_op[i]; i_data_rs = v_a[i]; i_data_rt = v_b[i];
      i_data_immext = 32'h100;
      step();
      chk($sformatf("alu_op%0d", v_op[i]), o_data_alures, v_exp[i]);
    end

    // Branches with forwarded operands
    idle_inputs();
    i_con_bop = 3'd1; i_con_Efamux = 3'd1; i_data_FEalures = 32'h55;
    i_con_Efbmux = 3'd4; i_data_FWmemout = 32'h55; i_data_rt = 32'h66;
    #1 chk("beq_taken", {31'd0, o_con_ifbranch}, 32'd1);
    i_con_bop = 3'd2;
    #1 chk("bne_not", {31'd0, o_con_ifbranch}, 32'd0);
    i_con_bop = 3'd5; i_data_FEalures = 32'hFFFFFFF0;
    #1 chk("bltz_taken", {31'd0, o_con_ifbranch}, 32'd1);
    i_con_bop = 3'd4; i_data_FEalures = 32'd0;
    #1 chk("bgtz_zero", {31'd0, o_con_ifbranch}, 32'd0);
    i_con_bop = 3'd3;
    #1 chk("blez_zero", {31'd0, o_con_ifbranch}, 32'd1);
    step();

    // Hold over flush, then flush alone
    idle_inputs();
    i_con_Ealuctrl = 4'd2; i_data_rs = 32'd2; i_data_rt = 32'd3; i_con_Wregwrite = 1;
    step();
    chk("pre_hold", o_data_alures, 32'd5);
    i_data_rs = 32'd10; i_data_rt = 32'd10; i_con_hold = 1; i_con_flush = 1;
    step();
    chk("hold_data", o_data_alures, 32'd5);
    chk("hold_ctrl", {31'd0, o_con_Wregwrite}, 32'd1);
    i_con_hold = 0;
    step();
    chk("flush_data", o_data_alures, 32'd20);
    chk("flush_ctrl", {31'd0, o_con_Wregwrite}, 32'd0);

    // MULT -3 * 7 with an ALU op and a stalled MFHI during BUSY
    idle_inputs();
    i_con_Emdop = 3'd1; i_data_rs = 32'hFFFFFFFD; i_data_rt = 32'd7;
    step();
    idle_inputs();
    i_con_Ealuctrl = 4'd2; i_data_rs = 32'd2; i_data_rt = 32'd3; i_con_Wregwrite = 1;
    #1 chk("mul_busy", {31'd0, o_con_mdbusy}, 32'd1);
    chk("alu_no_stall", {31'd0, o_con_stall}, 32'd0);
    step();
    chk("alu_during_busy", o_data_alures, 32'd5);
    chk("alu_during_busy_we", {31'd0, o_con_Wregwrite}, 32'd1);
    idle_inputs();
    i_con_Emfhl = 2'd1; i_con_Wregwrite = 1;
    #1 chk("mfhi_stall", {31'd0, o_con_stall}, 32'd1);
    step();
    chk("stall_bubble", {31'd0, o_con_Wregwrite}, 32'd0);
    n = 0;
    while (o_con_stall && n < 100) begin n++; step(); end
    chk("mfhi_stall_cycles", n, 32'd30);
    chk("busy_done", {31'd0, o_con_mdbusy}, 32'd0);
    step();
    chk("mult_hi", o_data_alures, 32'hFFFFFFFF);
    chk("mfhi_we", {31'd0, o_con_Wregwrite}, 32'd1);
    read_hl("mult_lo", 2'd2, 32'hFFFFFFEB);

`ifdef EXECUTE_MD_DIV_EN
    // DIVU 100/7 followed at once by MFLO
    idle_inputs();
    i_con_Emdop = 3'd4; i_data_rs = 32'd100; i_data_rt = 32'd7;
    step();
    idle_inputs();
    i_con_Emfhl = 2'd2; i_con_Wregwrite = 1;
    n = 0;
    #1;
    while (o_con_stall && n < 100) begin n++; step(); end
    chk("divu_stall_cycles", n, 32'd32);
    step();
    chk("divu_lo", o_data_alures, 32'd14);
    read_hl("divu_hi", 2'd1, 32'd2);

    idle_inputs();
    i_con_Emdop = 3'd3; i_data_rs = 32'd5; i_data_rt = 32'd0;
    step();
    wait_idle();
    read_hl("div0_lo", 2'd2, 32'hFFFFFFFF);
    read_hl("div0_hi", 2'd1, 32'd5);

    idle_inputs();
    i_con_Emdop = 3'd3; i_data_rs = 32'h80000000; i_data_rt = 32'hFFFFFFFF;
    step();
    wait_idle();
    read_hl("divmin_lo", 2'd2, 32'h80000000);
    read_hl("divmin_hi", 2'd1, 32'd0);

    idle_inputs();
    i_con_Emdop = 3'd3; i_data_rs = 32'hFFFFFFF9; i_data_rt = 32'd2;
    step();
    wait_idle();
    read_hl("divneg_lo", 2'd2, 32'hFFFFFFFD);
    read_hl("divneg_hi", 2'd1, 32'hFFFFFFFF);
`else
    // Divider absent: DIVU and DIV leave busy low and HI/LO untouched
    idle_inputs();
    i_con_Emdop = 3'd4; i_data_rs = 32'd100; i_data_rt = 32'd7;
    step();
    chk("divu_nobusy", {31'd0, o_con_mdbusy}, 32'd0);
    idle_inputs();
    i_con_Emdop = 3'd3; i_data_rs = 32'd5; i_data_rt = 32'd0;
    step();
    chk("div_nobusy", {31'd0, o_con_mdbusy}, 32'd0);
    idle_inputs();
    i_con_Emfhl = 2'd2;
    #1 chk("nodiv_no_stall", {31'd0, o_con_stall}, 32'd0);
    read_hl("nodiv_lo", 2'd2, 32'hFFFFFFEB);
    read_hl("nodiv_hi", 2'd1, 32'hFFFFFFFF);
`endif

    // MTHI / MTLO
    idle_inputs();
    i_con_Emdop = 3'd5; i_data_rs = 32'h1111;
    step();
    chk("mthi_nobusy", {31'd0, o_con_mdbusy}, 32'd0);
    i_con_Emdop = 3'd6; i_data_rs = 32'h2222;
    step();
    read_hl("mthi", 2'd1, 32'h1111);
    read_hl("mtlo", 2'd2, 32'h2222);

    // Reset in cycle 10 of a MULT
    idle_inputs();
    i_con_Emdop = 3'd2; i_data_rs = 32'd3; i_data_rt = 32'd5;
    step();
    idle_inputs();
    for (int i = 1; i < 10; i++) step();
    chk("mid_busy", {31'd0, o_con_mdbusy}, 32'd1);
    i_nrst = 0;
    #1 chk("rst_mid_busy", {31'd0, o_con_mdbusy}, 32'd0);
    chk("rst_mid_alures", o_data_alures, 32'd0);
    step();
    i_nrst = 1;
    step();
    idle_inputs();
    i_con_Emfhl = 2'd1;
    #1 chk("post_rst_no_stall", {31'd0, o_con_stall}, 32'd0);
    read_hl("post_rst_hi", 2'd1, 32'd0);
    read_hl("post_rst_lo", 2'd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
